// File: rtl/position_snapshot_pio.sv
// Avalon-MM PIO that samples packed position channels, snapshots them on demand or on change,
// flags per-channel changes and raises a maskable level interrupt.
module position_snapshot_pio #(
    parameter int CHANNELS = 3,
    parameter int WIDTH    = 12
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [4:0]                address,
    input  logic                      write,
    input  logic [31:0]               writedata,
    output logic [31:0]               readdata,
    input  logic [CHANNELS*WIDTH-1:0] in_port,
    output logic                      irq
);

    localparam int PW = CHANNELS * WIDTH;

    logic [PW-1:0]       in_reg_q, prev_q, snap_q, snap_d;
    logic                in_valid_q, prev_valid_q;
    logic                auto_q, auto_d;
    logic [CHANNELS-1:0] mask_q, mask_d, change_q, change_d;
    logic [CHANNELS-1:0] set_s, clr_s;
    logic [15:0]         cnt_q, cnt_d;
    logic [31:0]         rdata_q, rd_s;
    logic                irq_q, irq_d;
    logic                ctrl_wr_s, mask_wr_s, chg_wr_s, snap_evt_s;
    logic                unused_s;

    function automatic logic [WIDTH-1:0] chan_sel(input logic [PW-1:0] v, input logic [2:0] idx);
        chan_sel = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            chan_sel = (idx == 3'(i)) ? v[i*WIDTH +: WIDTH] : chan_sel;
        end
    endfunction

    assign unused_s = ^writedata;

    // Next-state logic for control, change flags, snapshots and interrupt.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            // prev_valid_q holds off detection until prev_q tracks real post-reset data
            set_s[i] = prev_valid_q && (in_reg_q[i*WIDTH +: WIDTH] != prev_q[i*WIDTH +: WIDTH]);
        end
        ctrl_wr_s  = write && (address == 5'h10);
        mask_wr_s  = write && (address == 5'h11);
        chg_wr_s   = write && (address == 5'h12);
        auto_d     = ctrl_wr_s ? writedata[1] : auto_q;
        mask_d     = mask_wr_s ? writedata[CHANNELS-1:0] : mask_q;
        clr_s      = chg_wr_s ? writedata[CHANNELS-1:0] : {CHANNELS{1'b0}};
        change_d   = (change_q & ~clr_s) | set_s;
        snap_evt_s = (ctrl_wr_s && writedata[0]) || (auto_q && (|set_s));
        snap_d     = snap_evt_s ? in_reg_q : snap_q;
        cnt_d      = cnt_q + 16'(snap_evt_s);
        irq_d      = |(change_d & mask_d);
    end

    // Read mux; unmapped and out-of-range addresses return zero.
    always_comb begin
        rd_s = 32'd0;
        case (address[4:3])
            2'b00: rd_s = 32'(chan_sel(in_reg_q, address[2:0]));
            2'b01: rd_s = 32'(chan_sel(snap_q, address[2:0]));
            2'b10: begin
                case (address[2:0])
                    3'd0:    rd_s = {30'd0, auto_q, 1'b0};
                    3'd1:    rd_s = 32'(mask_q);
                    3'd2:    rd_s = 32'(change_q);
                    3'd3:    rd_s = {16'd0, cnt_q};
                    default: rd_s = 32'd0;
                endcase
            end
            default: rd_s = 32'd0;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            in_reg_q     <= '0;
            prev_q       <= '0;
            in_valid_q   <= 1'b0;
            prev_valid_q <= 1'b0;
            snap_q       <= '0;
            auto_q       <= 1'b0;
            mask_q       <= '0;
            change_q     <= '0;
            cnt_q        <= 16'd0;
            rdata_q      <= 32'd0;
            irq_q        <= 1'b0;
        end else begin
            in_reg_q     <= in_port;
            prev_q       <= in_reg_q;
            in_valid_q   <= 1'b1;
            prev_valid_q <= in_valid_q;
            snap_q       <= snap_d;
            auto_q       <= auto_d;
            mask_q       <= mask_d;
            change_q     <= change_d;
            cnt_q        <= cnt_d;
            rdata_q      <= rd_s;
            irq_q        <= irq_d;
        end
    end

    assign readdata = rdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_position_snapshot_pio.sv
// Directed self-checking bench for position_snapshot_pio (CHANNELS=3, WIDTH=12).
module tb_position_snapshot_pio;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [4:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [35:0] in_port;
    logic        irq;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] d;

    position_snapshot_pio #(.CHANNELS(3), .WIDTH(12)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .write(write),
        .writedata(writedata), .readdata(readdata), .in_port(in_port), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] v);
        address = a; writedata = v; write = 1'b1;
        tick();
        write = 1'b0; writedata = 32'd0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] v);
        address = a;
        tick();
        v = readdata;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; address = 5'd0; write = 1'b0; writedata = 32'd0; in_port = 36'd0;
        tick(); tick(); tick();
        n_checks++; if (readdata !== 32'd0) begin n_fail++; $display("FAIL reset_readdata: got %h expected %h", readdata, 32'd0); end
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", irq); end
        reset_n = 1'b1;
        rd(5'h10, d); n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL reset_ctrl: got %h expected 0", d); end
        rd(5'h11, d); n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL reset_mask: got %h expected 0", d); end
        rd(5'h13, d); n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL reset_cnt: got %h expected 0", d); end
    endtask

    task automatic test_live();
        in_port = {12'h000, 12'hABC, 12'h000};
        address = 5'h01;
        tick();
        n_checks++; if (readdata !== 32'd0) begin n_fail++; $display("FAIL live_edge1: got %h expected 0", readdata); end
        tick();
        n_checks++; if (readdata !== 32'h00000ABC) begin n_fail++; $display("FAIL live_edge2: got %h expected 00000abc", readdata); end
        rd(5'h05, d); n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL live_out_of_range: got %h expected 0", d); end
        rd(5'h1F, d); n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL unmapped_read: got %h expected 0", d); end
    endtask

    task automatic test_snapshot();
        in_port = {12'h456, 12'hABC, 12'h123};
        tick(); tick();
        wr(5'h10, 32'h1);
        in_port = {12'hFFF, 12'h111, 12'h222};
        rd(5'h08, d); n_checks++; if (d !== 32'h123) begin n_fail++; $display("FAIL snap0: got %h expected 123", d); end
        rd(5'h09, d); n_checks++; if (d !== 32'hABC) begin n_fail++; $display("FAIL snap1: got %h expected abc", d); end
        rd(5'h0A, d); n_checks++; if (d !== 32'h456) begin n_fail++; $display("FAIL snap2: got %h expected 456", d); end
        rd(5'h13, d); n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL snap_cnt: got %h expected 1", d); end
        rd(5'h10, d); n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL ctrl_read: got %h expected 0", d); end
        wr(5'h08, 32'h0000_0777);
        rd(5'h08, d); n_checks++; if (d !== 32'h123) begin n_fail++; $display("FAIL ro_write_ignored: got %h expected 123", d); end
    endtask

    task automatic test_change_irq();
        wr(5'h12, 32'hFFFF_FFFF);
        wr(5'h11, 32'hFFFF_FFFA);
        rd(5'h11, d); n_checks++; if (d !== 32'h2) begin n_fail++; $display("FAIL mask_low_bits: got %h expected 2", d); end
        rd(5'h12, d); n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL change_cleared: got %h expected 0", d); end
        in_port = in_port ^ {12'h000, 12'h001, 12'h000};
        address = 5'h12;
        tick(); tick(); tick();
        n_checks++; if (readdata !== 32'h2) begin n_fail++; $display("FAIL change_ch1: got %h expected 2", readdata); end
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_ch1: got %b expected 1", irq); end
        wr(5'h12, 32'h2);
        tick();
        n_checks++; if (readdata !== 32'h0) begin n_fail++; $display("FAIL w1c_ch1: got %h expected 0", readdata); end
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_after_clear: got %b expected 0", irq); end
        in_port = in_port ^ {12'h000, 12'h000, 12'h001};
        tick(); tick(); tick();
        n_checks++; if (readdata !== 32'h1) begin n_fail++; $display("FAIL change_ch0: got %h expected 1", readdata); end
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_masked: got %b expected 0", irq); end
    endtask

    task automatic test_set_wins();
        wr(5'h12, 32'h7);
        tick(); tick();
        in_port = in_port ^ {12'h000, 12'h000, 12'h001};
        tick();
        wr(5'h12, 32'h1);
        rd(5'h12, d); n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL set_wins: got %h expected 1", d); end
    endtask

    task automatic test_auto_wrap();
        wr(5'h12, 32'h7);
        wr(5'h10, 32'h2);
        rd(5'h10, d); n_checks++; if (d !== 32'h2) begin n_fail++; $display("FAIL auto_read: got %h expected 2", d); end
        // SNAP_CNT is 1 here, so 65534 single-cycle changes bring it to 0xFFFF
        for (int i = 0; i < 65534; i++) begin
            in_port = in_port ^ {12'h001, 12'h000, 12'h000};
            tick();
        end
        tick(); tick(); tick();
        rd(5'h13, d); n_checks++; if (d !== 32'hFFFF) begin n_fail++; $display("FAIL cnt_preload: got %h expected ffff", d); end
        in_port = in_port ^ {12'h001, 12'h000, 12'h000};
        tick(); tick(); tick();
        rd(5'h13, d); n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL cnt_wrap: got %h expected 0", d); end
        rd(5'h0A, d); n_checks++; if (d !== {20'd0, in_port[35:24]}) begin n_fail++; $display("FAIL auto_snap2: got %h expected %h", d, {20'd0, in_port[35:24]}); end
        in_port = in_port ^ {12'h000, 12'h000, 12'h010};
        tick();
        wr(5'h10, 32'h3);
        tick(); tick();
        rd(5'h13, d); n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL manual_auto_once: got %h expected 1", d); end
        rd(5'h08, d); n_checks++; if (d !== {20'd0, in_port[11:0]}) begin n_fail++; $display("FAIL manual_auto_snap0: got %h expected %h", d, {20'd0, in_port[11:0]}); end
    endtask

    task automatic test_reset_mid();
        wr(5'h10, 32'h0);
        wr(5'h11, 32'h7);
        in_port = 36'h5A5_3C3_0F0;
        tick(); tick(); tick();
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_before_reset: got %b expected 1", irq); end
        reset_n = 1'b0; address = 5'h11; writedata = 32'h7; write = 1'b1;
        tick();
        reset_n = 1'b1; write = 1'b0; writedata = 32'd0;
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_mid_reset: got %b expected 0", irq); end
        n_checks++; if (readdata !== 32'd0) begin n_fail++; $display("FAIL rdata_mid_reset: got %h expected 0", readdata); end
        rd(5'h11, d); n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL mask_after_reset: got %h expected 0", d); end
        rd(5'h12, d); n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL change_post_reset1: got %h expected 0", d); end
        rd(5'h12, d); n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL change_post_reset2: got %h expected 0", d); end
        rd(5'h12, d); n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL change_post_reset3: got %h expected 0", d); end
        rd(5'h13, d); n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL cnt_after_reset: got %h expected 0", d); end
        rd(5'h09, d); n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL snap_after_reset: got %h expected 0", d); end
        rd(5'h10, d); n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL ctrl_after_reset: got %h expected 0", d); end
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_after_reset: got %b expected 0", irq); end
        rd(5'h02, d); n_checks++; if (d !== 32'h5A5) begin n_fail++; $display("FAIL live2_after_reset: got %h expected 5a5", d); end
    endtask

    initial begin
        test_reset();
        test_live();
        test_snapshot();
        test_change_irq();
        test_set_wins();
        test_auto_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
